fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port PCWrite, input, 1, from hazard detection; 0 holds PC.
REQ-004 SHALL have port IFIDWrite, input, 1, from hazard detection; 0 holds IF/ID register.
REQ-005 SHALL have port IFIDFlush, input, 1, from hazard detection; 1 loads a bubble into IF/ID.
REQ-006 SHALL have port Branch, input, 2, redirect code: 00 none, 01 branch taken, 10 jump, 11 jump-register.
REQ-007 SHALL have ports BranchTarget, JumpTarget, JRTarget, input, 32 each, redirect addresses.
REQ-008 SHALL have port IMemAddr, output, 32, current PC to instruction memory (combinational read).
REQ-009 SHALL have port IMemData, input, 32, instruction at IMemAddr, same cycle.
REQ-010 SHALL have ports IFID_Instr, output, 32, and IFID_PCPlus4, output, 32, IF/ID register contents.
REQ-011 SHALL have port IFID_Valid, output, 1, 0 when IF/ID holds a bubble.
REQ-012 SHALL have port StallRun, output, 8, consecutive-stall cycle count, saturating.

Function
REQ-013 PC SHALL advance by 4 each cycle when PCWrite=1 and Branch=00; PC+4 SHALL wrap modulo 2^32.
REQ-014 Branch!=00 SHALL load PC with the selected target next edge, regardless of PCWrite.
REQ-015 Branch!=00 or IFIDFlush=1 SHALL load IF/ID with Instr=0x00000000 (nop), PCPlus4=0, Valid=0.
REQ-016 Flush SHALL take precedence over IFIDWrite=0; IFIDWrite=0 without flush SHALL hold IF/ID unchanged.
REQ-017 Otherwise IF/ID SHALL capture IMemData, PC+4, Valid=1; fetch-to-IF/ID latency one cycle.
REQ-018 FSM states SHALL be BOOT, RUN, STALL, REDIRECT, encoded 2 bits.
REQ-019 BOOT (after reset) SHALL last exactly one cycle with IF/ID Valid=0, then go to RUN.
REQ-020 RUN->STALL when PCWrite=0 and Branch=00; STALL->RUN when PCWrite=1 and Branch=00.
REQ-021 Any state ->REDIRECT when Branch!=00; REDIRECT->RUN next cycle unless Branch!=00 again (stay REDIRECT).
REQ-022 StallRun SHALL increment each cycle in STALL, saturate at 255, clear to 0 on leaving STALL.
REQ-023 Stall and redirect in the same cycle SHALL be resolved as redirect.

Reset
REQ-024 Rst_n=0 SHALL immediately set PC=0x00000000, IF/ID to bubble (Instr=0, PCPlus4=0, Valid=0), StallRun=0, state BOOT.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard the pending target and stall count.
REQ-026 Deassertion SHALL be taken on the next rising Clk edge only.

Configuration
REQ-027 Macro FETCH_PERF_COUNTERS_EN SHALL, when defined, add outputs StallTotal (32) and FlushTotal (32).
REQ-028 With it, StallTotal SHALL count STALL cycles and FlushTotal count cycles that load a bubble (except BOOT), both wrapping at 2^32, both reset to 0.
REQ-029 Without it, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Branch codes, FSM state encodings, NOP value (0x00000000) and reset PC SHALL live in shared package pipeline_pkg.
REQ-031 IF/ID register SHALL be a sub-module if_id_reg (write-enable, flush, async reset); PC, FSM, counters stay in fetch_stage.

Verification
REQ-032 Reset release, PCWrite=1, Branch=00 for 4 cycles -> IMemAddr 0,4,8,12; IF/ID Valid=0 first cycle, then PCPlus4=4,8,12.
REQ-033 PCWrite=0, IFIDWrite=0 for 3 cycles at PC=0x20 -> PC and IF/ID unchanged, StallRun 1,2,3, then 0 after release.
REQ-034 Branch=01, BranchTarget=0x100, with PCWrite=0 simultaneously -> next PC=0x100, IF/ID bubble, state REDIRECT.
REQ-035 PCWrite=0 for 300 cycles -> StallRun saturates at 255, no wrap.
REQ-036 Rst_n pulled low during STALL with StallRun=5 -> PC=0, StallRun=0, Valid=0 immediately, without a clock edge.
REQ-037 PC=0xFFFFFFFC, PCWrite=1 -> next PC=0x00000000, IFID_PCPlus4=0x00000000; with FETCH_PERF_COUNTERS_EN, FlushTotal increments once per Branch!=00 cycle.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the fetch stage.
// Contents:
//   branch_t       redirect code carried on Branch
//   fetch_state_t  fetch FSM encoding (2 bits)
//   NOP_INSTR      instruction loaded into IF/ID as a bubble
//   RESET_PC       PC value after reset
//   STALL_RUN_MAX  saturation value of the consecutive-stall counter
//   select_target  picks the redirect address for a non-zero branch code
package pipeline_pkg;

  typedef enum logic [1:0] {
    BR_NONE  = 2'b00,
    BR_TAKEN = 2'b01,
    BR_JUMP  = 2'b10,
    BR_JR    = 2'b11
  } branch_t;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_STALL    = 2'b10,
    ST_REDIRECT = 2'b11
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam logic [7:0]  STALL_RUN_MAX = 8'd255;

  // Only meaningful for br != BR_NONE; BR_NONE returns the branch target
  // but callers never use the result in that case.
  function automatic logic [31:0] select_target(
    input logic [1:0]  br,
    input logic [31:0] branch_target,
    input logic [31:0] jump_target,
    input logic [31:0] jr_target
  );
    logic [31:0] t;
    t = branch_target;
    case (br)
      BR_JUMP: t = jump_target;
      BR_JR:   t = jr_target;
      default: t = branch_target;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   write_en        1 captures the incoming fetch, 0 holds contents
//   flush           1 loads a bubble; wins over write_en
//   instr_in        instruction fetched this cycle
//   pc_plus4_in     PC+4 of the fetched instruction
//   instr, pc_plus4 register contents
//   valid           0 while the register holds a bubble
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_en,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= 32'h0;
      valid    <= 1'b0;
    end else if (write_en) begin
      instr    <= instr_in;
      pc_plus4 <= pc_plus4_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect mux, IF/ID register,
// fetch FSM and stall-run counter.
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   PCWrite           0 holds the PC (hazard stall)
//   IFIDWrite         0 holds the IF/ID register
//   IFIDFlush         1 loads a bubble into IF/ID
//   Branch            00 none, 01 branch, 10 jump, 11 jump-register
//   BranchTarget, JumpTarget, JRTarget   redirect addresses
//   IMemAddr          current PC to a combinational-read instruction memory
//   IMemData          instruction at IMemAddr, same cycle
//   IFID_Instr, IFID_PCPlus4, IFID_Valid IF/ID contents (Valid=0 is a bubble)
//   StallRun          consecutive STALL cycles, saturating at 255
//   State             current fetch FSM state (fetch_state_t encoding)
// Optional build macro FETCH_PERF_COUNTERS_EN adds:
//   StallTotal        cycles spent in STALL (wraps)
//   FlushTotal        cycles that loaded a bubble outside BOOT (wraps)
// IF/ID carries no handshake: IFID_Valid qualifies its contents every cycle,
// and hazard control is applied through PCWrite/IFIDWrite/IFIDFlush.
module fetch_stage
  import pipeline_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        IFIDFlush,
  input  logic [1:0]  Branch,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JRTarget,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [7:0]  StallRun,
  output logic [1:0]  State
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] StallTotal,
  output logic [31:0] FlushTotal
`endif
);

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_next;
  logic         redirect;
  logic         bubble;
  fetch_state_t state;
  logic [7:0]   stall_run;

  assign redirect = (Branch != BR_NONE);
  assign bubble   = redirect | IFIDFlush;
  assign pc_plus4 = pc + 32'd4;  // wraps naturally at 2^32

  // A redirect overrides a stall request: the target is always taken.
  always_comb begin
    pc_next = pc;
    if (redirect) begin
      pc_next = select_target(Branch, BranchTarget, JumpTarget, JRTarget);
    end else if (PCWrite) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .write_en    (IFIDWrite),
    .flush       (bubble),
    .instr_in    (IMemData),
    .pc_plus4_in (pc_plus4),
    .instr       (IFID_Instr),
    .pc_plus4    (IFID_PCPlus4),
    .valid       (IFID_Valid)
  );

  // Fetch FSM and stall-run counter. stall_run is updated together with the
  // state so that it reads 1 in the first STALL cycle and 0 everywhere else.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_BOOT;
      stall_run <= 8'd0;
    end else if (redirect) begin
      state     <= ST_REDIRECT;
      stall_run <= 8'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (!PCWrite) begin
            state     <= ST_STALL;
            stall_run <= 8'd1;
          end else begin
            stall_run <= 8'd0;
          end
        end
        ST_STALL: begin
          if (PCWrite) begin
            state     <= ST_RUN;
            stall_run <= 8'd0;
          end else if (stall_run != STALL_RUN_MAX) begin
            stall_run <= stall_run + 8'd1;
          end
        end
        default: begin  // BOOT and REDIRECT both fall back to RUN
          state     <= ST_RUN;
          stall_run <= 8'd0;
        end
      endcase
    end
  end

  assign IMemAddr = pc;
  assign StallRun = stall_run;
  assign State    = state;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] stall_total;
  logic [31:0] flush_total;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_total <= 32'd0;
      flush_total <= 32'd0;
    end else begin
      if (state == ST_STALL) begin
        stall_total <= stall_total + 32'd1;
      end
      if (bubble && (state != ST_BOOT)) begin
        flush_total <= flush_total + 32'd1;
      end
    end
  end

  assign StallTotal = stall_total;
  assign FlushTotal = flush_total;
`endif

endmodule
